uart_receiver: RTL

Serial-to-parallel UART receiver for 8N1 frames; the receive-side counterpart to the design's UART transmitter. Samples the asynchronous `rx` line at 16× the bit rate using the shared baud tick generator, validates start and stop bits, and presents each received byte with a one-cycle completion strobe. Sits between the board RX pin and the byte-consuming logic (loopback/echo or command path).

---
 rtl/uart_receiver.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, start/stop validation.
// Emits each good byte with a one-cycle rx_done strobe, or a frame_err strobe on a bad stop bit.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic                   rx_meta_q, rx_s_q, rx_s_d_q;
    logic                   fall_edge;

    // Synchronizer and edge-detect flops reset high so release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_s_d_q  <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_s_d_q  <= rx_s_q;
        end
    end

    assign fall_edge = rx_s_d_q & ~rx_s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall_edge) begin
                    tick_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (br_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (rx_s_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            bit_d   = '0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (br_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (br_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = ST_IDLE;
                        if (rx_s_q) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        state_dbg = state_q;
        rx_data   = data_q;
        rx_done   = done_q;
        frame_err = ferr_q;
    end

endmodule
